// File: rtl/fmap_reader.sv
// fmap_reader: streams packed 64-bit feature-map words from both BRAM32k ports as signed pixel pairs.
// Latency: first pixel RD_LAT+2 cycles after start (2 cycles, a leading pad pair, with FMAP_RD_ZPAD_EN).
// Backpressure: pix_ready low holds the current pair; fetching pauses once the 2-entry word buffer is full.
// Build option: define FMAP_RD_ZPAD_EN to frame every row with one zero pixel pair on each side.
module fmap_reader #(
  parameter int RD_LAT       = 1,
  parameter int ROW_STRIDE   = 128,
  parameter int PORTB_OFFSET = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] base_addr,
  input  logic [6:0]  words_per_row,
  input  logic [7:0]  num_rows,
  output logic        busy,
  output logic        done,
  output logic        en_BRAM32k,
  output logic [11:0] addr_BRAM32k_1,
  output logic [11:0] addr_BRAM32k_2,
  input  logic [63:0] dout_BRAM32k_1,
  input  logic [63:0] dout_BRAM32k_2,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pixA,
  output logic [7:0]  pixB,
  output logic        row_last,
  output logic        frame_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_wpr;
  logic [7:0]        r_rows;
  logic [6:0]        r_fw;
  logic [7:0]        r_fr;
  logic [11:0]       r_row_base;
  logic              r_fetch_more;
  logic [RD_LAT-1:0] r_pend;
  logic [63:0]       r_buf_a [2];
  logic [63:0]       r_buf_b [2];
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;
  logic [2:0]        r_k;
  logic [6:0]        r_sw;
  logic [7:0]        r_sr;

  logic        w_start_ok, w_degen, w_issue, w_capture, w_hs, w_pop, w_vld;
  logic        w_rl, w_frame_end, w_word_last, w_row_fin;
  logic [2:0]  w_inflight;
  logic [11:0] w_addr;
  logic [7:0]  w_byte_a, w_byte_b;

  assign w_start_ok  = start && (r_state == S_IDLE);
  assign w_degen     = (words_per_row == 7'd0) || (num_rows == 8'd0);

  // Count reads still travelling through the BRAM read pipeline.
  always_comb begin
    w_inflight = 3'd0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + {2'b00, r_pend[i]};
  end

  // Buffered plus in-flight words never exceed the two buffer slots.
  assign w_issue     = (r_state == S_RUN) && r_fetch_more && (({1'b0, r_cnt} + w_inflight) < 3'd2);
  assign w_capture   = r_pend[RD_LAT-1];
  assign w_addr      = r_row_base + {5'd0, r_fw};
  assign w_word_last = (r_sw == r_wpr - 7'd1);
  assign w_row_fin   = (r_sr == r_rows - 8'd1);
  assign w_byte_a    = r_buf_a[r_rp][8*(7-r_k) +: 8];
  assign w_byte_b    = r_buf_b[r_rp][8*(7-r_k) +: 8];

`ifdef FMAP_RD_ZPAD_EN
  localparam logic [1:0] PH_LEAD = 2'd0, PH_DATA = 2'd1, PH_TRAIL = 2'd2;
  logic [1:0] r_ph;
  logic       r_first;

  // Pads need no BRAM data; only the very first lead pad waits one cycle after start.
  assign w_vld       = (r_state == S_RUN) &&
                       ((r_ph == PH_LEAD) ? !r_first :
                        (r_ph == PH_DATA) ? (r_cnt != 2'd0) : 1'b1);
  assign w_rl        = (r_ph == PH_TRAIL);
  assign w_pop       = w_hs && (r_ph == PH_DATA) && (r_k == 3'd7);
  assign pixA        = (w_vld && (r_ph == PH_DATA)) ? w_byte_a : 8'd0;
  assign pixB        = (w_vld && (r_ph == PH_DATA)) ? w_byte_b : 8'd0;
`else
  assign w_vld       = (r_state == S_RUN) && (r_cnt != 2'd0);
  assign w_rl        = (r_k == 3'd7) && w_word_last;
  assign w_pop       = w_hs && (r_k == 3'd7);
  assign pixA        = w_vld ? w_byte_a : 8'd0;
  assign pixB        = w_vld ? w_byte_b : 8'd0;
`endif

  assign w_hs        = w_vld && pix_ready;
  assign w_frame_end = w_hs && w_rl && w_row_fin;

  assign pix_valid      = w_vld;
  assign row_last       = w_vld && w_rl;
  assign frame_last     = w_vld && w_rl && w_row_fin;
  assign en_BRAM32k     = w_issue;
  assign addr_BRAM32k_1 = w_issue ? w_addr : 12'd0;
  assign addr_BRAM32k_2 = w_issue ? (w_addr + 12'(PORTB_OFFSET)) : 12'd0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_degen ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_frame_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch side: configuration latch, row/word address walk and read pipeline tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wpr        <= '0;
      r_rows       <= '0;
      r_fw         <= '0;
      r_fr         <= '0;
      r_row_base   <= '0;
      r_fetch_more <= 1'b0;
      r_pend       <= '0;
    end else begin
      r_pend <= (r_pend << 1) | RD_LAT'(w_issue);
      if (w_start_ok) begin
        r_wpr        <= words_per_row;
        r_rows       <= num_rows;
        r_fw         <= '0;
        r_fr         <= '0;
        r_row_base   <= base_addr;
        r_fetch_more <= !w_degen;
      end else if (w_issue) begin
        if (r_fw == r_wpr - 7'd1) begin
          r_fw       <= '0;
          r_fr       <= r_fr + 8'd1;
          r_row_base <= r_row_base + 12'(ROW_STRIDE);
          if (r_fr == r_rows - 8'd1) r_fetch_more <= 1'b0;
        end else begin
          r_fw <= r_fw + 7'd1;
        end
      end
    end
  end

  // Two-entry word-pair buffer: push on read return, pop after the eighth pixel of the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_a[0] <= '0;
      r_buf_a[1] <= '0;
      r_buf_b[0] <= '0;
      r_buf_b[1] <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
    end else if (w_start_ok) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_capture) begin
        r_buf_a[r_wp] <= dout_BRAM32k_1;
        r_buf_b[r_wp] <= dout_BRAM32k_2;
        r_wp          <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_capture} - {1'b0, w_pop};
    end
  end

  // Stream side: byte, word and row position of the pixel currently offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k  <= '0;
      r_sw <= '0;
      r_sr <= '0;
`ifdef FMAP_RD_ZPAD_EN
      r_ph    <= PH_LEAD;
      r_first <= 1'b0;
`endif
    end else if (w_start_ok) begin
      r_k  <= '0;
      r_sw <= '0;
      r_sr <= '0;
`ifdef FMAP_RD_ZPAD_EN
      r_ph    <= PH_LEAD;
      r_first <= 1'b1;
`endif
    end else begin
`ifdef FMAP_RD_ZPAD_EN
      r_first <= 1'b0;
      if (w_hs) begin
        if (r_ph == PH_LEAD) begin
          r_ph <= PH_DATA;
        end else if (r_ph == PH_TRAIL) begin
          r_ph <= PH_LEAD;
          r_sr <= r_sr + 8'd1;
        end else if (r_k == 3'd7) begin
          r_k <= '0;
          if (w_word_last) begin
            r_sw <= '0;
            r_ph <= PH_TRAIL;
          end else begin
            r_sw <= r_sw + 7'd1;
          end
        end else begin
          r_k <= r_k + 3'd1;
        end
      end
`else
      if (w_hs) begin
        if (r_k == 3'd7) begin
          r_k <= '0;
          if (w_word_last) begin
            r_sw <= '0;
            r_sr <= r_sr + 8'd1;
          end else begin
            r_sw <= r_sw + 7'd1;
          end
        end else begin
          r_k <= r_k + 3'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_fmap_reader.sv
// Randomized scoreboard bench for fmap_reader: a row/word/byte loop model fills expectation queues,
// a negedge monitor pops and compares every BRAM read and every pixel handshake.
// Build with FMAP_RD_ZPAD_EN defined to exercise the padded row format.
module tb_fmap_reader;

  localparam int RD_LAT = 1;
`ifdef FMAP_RD_ZPAD_EN
  localparam int FIRST_LAT = 2;
`else
  localparam int FIRST_LAT = RD_LAT + 2;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       rl;
    logic       fl;
    logic       dat;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [6:0]  words_per_row;
  logic [7:0]  num_rows;
  logic        busy, done, en_BRAM32k, pix_valid, pix_ready, row_last, frame_last;
  logic [11:0] addr_BRAM32k_1, addr_BRAM32k_2;
  logic [63:0] dout_BRAM32k_1, dout_BRAM32k_2;
  logic [7:0]  pixA, pixB;

  logic [63:0] mem [4096];
  pix_t        exp_q[$];
  logic [11:0] exp_addr_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc, first_cyc, last_hs_cyc, done_seen = 0;
  int   issued, consumed, total_pix;
  bit   first_seen, degen, bp_mode, prev_stall;
  logic [17:0] prev_out;
  pix_t        mon_e;
  logic [11:0] mon_a;

  fmap_reader #(.RD_LAT(RD_LAT), .ROW_STRIDE(128), .PORTB_OFFSET(128)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .words_per_row(words_per_row), .num_rows(num_rows), .busy(busy), .done(done),
    .en_BRAM32k(en_BRAM32k), .addr_BRAM32k_1(addr_BRAM32k_1), .addr_BRAM32k_2(addr_BRAM32k_2),
    .dout_BRAM32k_1(dout_BRAM32k_1), .dout_BRAM32k_2(dout_BRAM32k_2),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pixA(pixA), .pixB(pixB),
    .row_last(row_last), .frame_last(frame_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (en_BRAM32k) begin
      dout_BRAM32k_1 <= mem[addr_BRAM32k_1];
      dout_BRAM32k_2 <= mem[addr_BRAM32k_2];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every row, word and byte of the frame in order, using plain address arithmetic.
  task automatic build(input int base, input int wpr, input int rows);
    int          ad;
    logic [63:0] wa, wb;
    pix_t        p;
    for (int r = 0; r < rows; r++) begin
`ifdef FMAP_RD_ZPAD_EN
      p = '0;
      exp_q.push_back(p);
`endif
      for (int w = 0; w < wpr; w++) begin
        ad = (base + r * 128 + w) % 4096;
        wa = mem[ad];
        wb = mem[(ad + 128) % 4096];
        exp_addr_q.push_back(12'(ad));
        for (int k = 0; k < 8; k++) begin
          p.a   = wa[63 - 8 * k -: 8];
          p.b   = wb[63 - 8 * k -: 8];
`ifdef FMAP_RD_ZPAD_EN
          p.rl  = 1'b0;
`else
          p.rl  = (w == wpr - 1) && (k == 7);
`endif
          p.fl  = p.rl && (r == rows - 1);
          p.dat = 1'b1;
          exp_q.push_back(p);
        end
      end
`ifdef FMAP_RD_ZPAD_EN
      p = '0;
      p.rl = 1'b1;
      p.fl = (r == rows - 1);
      exp_q.push_back(p);
`endif
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic run_frame(input int base, input int wpr, input int rows, input bit bp, input bit poke);
    int d0;
    exp_q.delete();
    exp_addr_q.delete();
    build(base, wpr, rows);
    total_pix  = exp_q.size();
    issued     = 0;
    consumed   = 0;
    first_seen = 1'b0;
    degen      = (wpr == 0) || (rows == 0);
    bp_mode    = bp;
    @(posedge clk); #1;
    base_addr     = 12'(base);
    words_per_row = 7'(wpr);
    num_rows      = 8'(rows);
    start         = 1'b1;
    start_cyc     = cyc;
    d0            = done_seen;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      base_addr     = 12'(base + 7);
      words_per_row = 7'd1;
      num_rows      = 8'd1;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 20000 && done_seen == d0; i++) @(posedge clk);
    if (done_seen == d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done pulse for base=%0d wpr=%0d rows=%0d", base, wpr, rows);
    end
    repeat (4) @(posedge clk);
    check("done_count", 64'(done_seen), 64'(d0 + 1));
    check("pixels_left", 64'(exp_q.size()), 64'd0);
    check("reads_left", 64'(exp_addr_q.size()), 64'd0);
    if (!bp && !degen) check("no_bubbles", 64'(last_hs_cyc - first_cyc + 1), 64'(total_pix));
  endtask

  // Consumer ready: tied high, or a fresh random value every cycle under backpressure.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pix_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: reads, pixel handshakes, stall stability and done timing.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (en_BRAM32k) begin
        issued++;
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_read: addr=%0d required no read", addr_BRAM32k_1);
        end else begin
          mon_a = exp_addr_q.pop_front();
          check("rd_addr1", 64'(addr_BRAM32k_1), 64'(mon_a));
          check("rd_addr2", 64'(addr_BRAM32k_2), 64'(12'(mon_a + 12'd128)));
        end
        check("outstanding_le2", 64'(issued - consumed / 8 <= 2), 64'd1);
      end
      if (pix_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
          check("first_latency", 64'(cyc - start_cyc), 64'(FIRST_LAT));
        end
        if (prev_stall) check("stall_hold", 64'({pixA, pixB, row_last, frame_last}), 64'(prev_out));
        if (pix_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_pixel: A=%0h B=%0h required none", pixA, pixB);
          end else begin
            mon_e = exp_q.pop_front();
            check("pixel", 64'({pixA, pixB, row_last, frame_last}),
                  64'({mon_e.a, mon_e.b, mon_e.rl, mon_e.fl}));
            if (mon_e.dat) consumed++;
          end
          last_hs_cyc = cyc;
        end
      end else if (prev_stall) begin
        check("valid_held", 64'(pix_valid), 64'd1);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = {pixA, pixB, row_last, frame_last};
      if (done) begin
        done_seen++;
        check("done_cycle", 64'(cyc), 64'(degen ? start_cyc + 1 : last_hs_cyc + 1));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int d0;
    rst           = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    words_per_row = '0;
    num_rows      = '0;
    bp_mode       = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
                                pix_valid, pixA, pixB, row_last, frame_last}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single word, single row with known contents.
    mem[0]   = 64'h0102_0304_0506_0708;
    mem[128] = 64'hF1F2_F3F4_F5F6_F7F8;
    run_frame(0, 1, 1, 1'b0, 1'b0);

    // Two words by two rows from base 10.
    run_frame(10, 2, 2, 1'b0, 1'b0);

    // Same frame under random backpressure.
    run_frame(10, 2, 2, 1'b1, 1'b0);
    run_frame(300, 3, 3, 1'b1, 1'b0);

    // Address wrap at the top of the 12-bit space.
    run_frame(4095, 2, 2, 1'b0, 1'b0);

    // Degenerate frames.
    run_frame(50, 2, 0, 1'b0, 1'b0);
    run_frame(50, 0, 3, 1'b0, 1'b0);

    // A second start while busy must not disturb the frame.
    run_frame(20, 2, 2, 1'b0, 1'b1);

    // Reset mid-frame.
    exp_q.delete();
    exp_addr_q.delete();
    build(40, 3, 2);
    issued     = 0;
    consumed   = 0;
    first_seen = 1'b0;
    degen      = 1'b0;
    @(posedge clk); #1;
    base_addr     = 12'd40;
    words_per_row = 7'd3;
    num_rows      = 8'd2;
    start         = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("reset_mid_outputs", 64'({busy, done, en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
                                    pix_valid, pixA, pixB, row_last, frame_last}), 64'd0);
    d0 = done_seen;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_seen), 64'(d0));
    check("idle_after_reset", 64'({busy, en_BRAM32k, pix_valid}), 64'd0);

    // Random frames after recovery.
    for (int n = 0; n < 5; n++) begin
      fill_mem();
      run_frame($urandom_range(0, 4095), $urandom_range(1, 4), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_reader.md
Name: fmap_reader

Overview:
- Read-side counterpart of the layer writeback path. Fetches packed 64-bit feature-map words from the dual-port 32k BRAM on both ports in parallel.
- Port 2 reads the second channel, 128 words above port 1.
- Unpacks each word into eight signed 8-bit pixels, most-significant byte first, and streams them as pixel pairs (A from port 1, B from port 2) to the PE groups over a valid/ready handshake.
- Sits between the BRAM32k and the PE-group input muxes for layers that consume a previous layer's output.

Parameters:
- RD_LAT, 1, BRAM read latency in cycles (1 or 2); data appears RD_LAT cycles after an enabled address.
- ROW_STRIDE, 128, address increment between consecutive rows.
- PORTB_OFFSET, 128, port-2 address offset from port-1 address.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; latches configuration and begins a frame.
- base_addr  input  12  port-1 word address of row 0, word 0.
- words_per_row  input  7  64-bit words per row.
- num_rows  input  8  rows per frame.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the final pixel handshake.
- en_BRAM32k  output  1  read enable for both ports.
- addr_BRAM32k_1  output  12  port-1 read address.
- addr_BRAM32k_2  output  12  port-2 read address, always addr_BRAM32k_1 + PORTB_OFFSET (mod 4096).
- dout_BRAM32k_1  input  64  port-1 read data.
- dout_BRAM32k_2  input  64  port-2 read data.
- pix_valid  output  1  pixA/pixB valid.
- pix_ready  input  1  consumer accepts when high with pix_valid.
- pixA  output  8  signed pixel from port-1 word.
- pixB  output  8  signed pixel from port-2 word.
- row_last  output  1  qualifies the final pixel of a row.
- frame_last  output  1  qualifies the final pixel of the frame.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters, word buffer and in-flight count cleared.
- FSM states:
  - IDLE: accept start.
  - RUN: fetch and stream.
  - DONE: one cycle, done=1, then IDLE.
- start outside IDLE is ignored.
- start with words_per_row==0 or num_rows==0: go straight to DONE. The done pulse occurs the cycle after start, with no BRAM reads.
- Addressing:
  - Row counter r and word counter w are incremented, never multiplied.
  - Read address is base + r*ROW_STRIDE + w, 12-bit wrap-around.
  - w wraps at words_per_row, and r then increments. Last fetch is at r = num_rows-1, w = words_per_row-1.
- Fetch side:
  - Word buffer holds 2 entries; each entry is a port-1/port-2 word pair.
  - A read is issued (en_BRAM32k=1 for one cycle, address presented) only when buffered words + in-flight reads < 2 and fetches remain.
  - Returned data is captured exactly RD_LAT cycles after issue.
  - en_BRAM32k=0 whenever no read is issued.
- Stream side:
  - Head word pair is unpacked by byte index k = 0..7; pixel k is bits [63-8k : 56-8k] of each port's word.
  - pixA/pixB are stable and pix_valid is held from assertion until handshake. pix_valid never drops without a handshake.
  - On the handshake at k==7, the head entry is popped and k resets to 0.
- row_last and frame_last are asserted alongside pix_valid for the affected pixel and hold with it.
- Latency: first pix_valid is asserted exactly RD_LAT+2 cycles after start.
- Throughput: with pix_ready tied high, one pixel pair per cycle with no bubbles across word or row boundaries.
- Backpressure: pix_ready low stalls streaming. Fetch continues only until the buffer is full, and no data is lost.
- done: asserted the cycle after the final handshake; busy falls in the same cycle.
- Reset mid-frame: returns to IDLE immediately. In-flight read data is discarded, and no done pulse is produced.

Optional Feature:
- FMAP_RD_ZPAD_EN defined:
  - Each row is framed by one zero pixel pair before word 0 and one after the last word, with no BRAM read for pad pixels.
  - A row is 8*words_per_row+2 pixels, and row_last marks the trailing pad.
  - First pix_valid (the leading pad) is at 2 cycles after start.
- Undefined: no padding, exactly 8*words_per_row pixels per row.

Test Plan:
- RD_LAT=1, base=0, words_per_row=1, num_rows=1:
  - Stimulus: mem[0]=64'h0102_0304_0506_0708, mem[128]=64'hF1F2_F3F4_F5F6_F7F8, pix_ready=1.
  - Expected: pixA=01..08 and pixB=F1..F8 on consecutive cycles; first valid at start+3; row_last and frame_last on the 8th pixel; done the next cycle.
- words_per_row=2, num_rows=2, base=10:
  - Expected: read addresses 10, 11, 138, 139 on port 1 and 138, 139, 266, 267 on port 2.
  - Expected: 32 pixel pairs with no bubbles; row_last on pixels 16 and 32.
- Backpressure: pix_ready toggled 1/0 pseudo-randomly.
  - Expected: outputs stable while stalled, sequence identical to the unstalled run, at most 2 words buffered, never more than 2 reads outstanding.
- base=4095, words_per_row=2:
  - Expected: addresses 4095 then 0 on port 1, 127 then 128 on port 2.
- Degenerate and illegal inputs:
  - num_rows=0: done at start+1, en_BRAM32k never high.
  - start pulsed while busy: ignored.
  - rst low mid-frame: all outputs 0, no done pulse.
- FMAP_RD_ZPAD_EN defined, words_per_row=1:
  - Expected: 10 pairs per row, first and last 00/00.
